mm_arb: RTL

- Two-master arbiter that shares the single master port of the memory-mapped register interconnect.
- M0 is the host-side bus bridge (I2C/SPI slave front end); M1 is an internal agent (power sequencer or self-test engine).
- Grants round-robin, sequences one register access at a time, and honours the interconnect's registered read-data latency.
- Returns captured read data and a one-cycle ack to the owning requester.

---
 rtl/mm_pkg.sv | 27 ++
 rtl/mm_arb_if.sv | 43 ++++
 rtl/mm_rr_arb2.sv | 34 +++
 rtl/mm_arb.sv | 117 +++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the memory-mapped register interconnect arbiter:
// default bus widths, register map addresses and the arbiter FSM encoding.
package mm_pkg;

    localparam int MM_ADDR_WIDTH_DEF = 8;
    localparam int MM_DATA_WIDTH_DEF = 16;

    localparam logic [MM_ADDR_WIDTH_DEF-1:0] PID       = 8'h00;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] TST       = 8'h02;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] INT_PND   = 8'h04;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] INT_CLR   = 8'h06;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] INT_MSK   = 8'h08;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] SWDT_CTRL = 8'h0A;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] SWDT_VAL  = 8'h0C;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] LED_CTRL  = 8'h0E;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] PWR_CTRL  = 8'h10;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] PSU_STA   = 8'h12;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] PWR_STA   = 8'h14;
    localparam logic [MM_ADDR_WIDTH_DEF-1:0] PWR_ERR   = 8'h16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } mm_state_e;

endpackage

// File: rtl/mm_arb_if.sv
// Bundle of the two requester ports and the shared interconnect master port.
// The slave modport is the arbiter's view; master is the requester/interconnect side.
interface mm_arb_if import mm_pkg::*; #(
    parameter int ADDR_W = MM_ADDR_WIDTH_DEF,
    parameter int DATA_W = MM_DATA_WIDTH_DEF
);
    logic              req0_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [DATA_W-1:0] wdata0_i;
    logic              we0_i;
    logic              ack0_o;
    logic [DATA_W-1:0] rdata0_o;

    logic              req1_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata1_i;
    logic              we1_i;
    logic              ack1_o;
    logic [DATA_W-1:0] rdata1_o;

    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic              m_we_o;
    logic [DATA_W-1:0] m_rdata_i;
    logic              busy_o;

    modport slave (
        input  req0_i, addr0_i, wdata0_i, we0_i,
        input  req1_i, addr1_i, wdata1_i, we1_i,
        input  m_rdata_i,
        output ack0_o, rdata0_o, ack1_o, rdata1_o,
        output m_addr_o, m_wdata_o, m_we_o, busy_o
    );

    modport master (
        output req0_i, addr0_i, wdata0_i, we0_i,
        output req1_i, addr1_i, wdata1_i, we1_i,
        output m_rdata_i,
        input  ack0_o, rdata0_o, ack1_o, rdata1_o,
        input  m_addr_o, m_wdata_o, m_we_o, busy_o
    );

endinterface

// File: rtl/mm_rr_arb2.sv
// Two-way round-robin picker. The pointer remembers the last granted master
// and resets to 1 so that master 0 wins the first contention.
module mm_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_q;

    // Pick the sole requester, or the one not granted last when both ask
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req[0] && req[1]) begin
            gnt_idx = ~last_q;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

    // Remember the winner only when the owner actually takes the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (upd_en && gnt_valid) begin
            last_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/mm_arb.sv
// Shares the interconnect master port between the host bridge (M0) and an
// internal agent (M1), one register access at a time, waiting RD_LAT edges
// for the registered read data before acknowledging the owner.
module mm_arb import mm_pkg::*; #(
    parameter int MM_ADDR_WIDTH = MM_ADDR_WIDTH_DEF,
    parameter int MM_DATA_WIDTH = MM_DATA_WIDTH_DEF,
    parameter int RD_LAT        = 1
) (
    input logic    clk_sys_i,
    input logic    rst_n_i,
    mm_arb_if.slave bus
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT);

    mm_state_e                state_q;
    logic                     owner_q;
    logic [1:0]               cnt_q;
    logic [MM_ADDR_WIDTH-1:0] m_addr_q;
    logic [MM_DATA_WIDTH-1:0] m_wdata_q;
    logic                     m_we_q;
    logic                     ack0_q;
    logic                     ack1_q;
    logic [MM_DATA_WIDTH-1:0] rdata0_q;
    logic [MM_DATA_WIDTH-1:0] rdata1_q;
    logic                     busy_q;

    logic                     gnt_valid;
    logic                     gnt_idx;
    logic                     arb_upd;

    assign arb_upd = (state_q == IDLE);

    mm_rr_arb2 u_rr (
        .clk       (clk_sys_i),
        .rst_n     (rst_n_i),
        .req       ({bus.req1_i, bus.req0_i}),
        .upd_en    (arb_upd),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Transaction sequencer: grant, hold the address for RD_LAT edges, capture and ack
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            cnt_q     <= 2'd0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_we_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        owner_q <= gnt_idx;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= XFER;
                        if (gnt_idx) begin
                            m_addr_q  <= bus.addr1_i;
                            m_wdata_q <= bus.wdata1_i;
                            m_we_q    <= bus.we1_i;
                        end else begin
                            m_addr_q  <= bus.addr0_i;
                            m_wdata_q <= bus.wdata0_i;
                            m_we_q    <= bus.we0_i;
                        end
                    end
                end
                XFER: begin
                    m_we_q <= 1'b0;
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        state_q <= DONE;
                        if (owner_q) begin
                            rdata1_q <= bus.m_rdata_i;
                            ack1_q   <= 1'b1;
                        end else begin
                            rdata0_q <= bus.m_rdata_i;
                            ack0_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    m_we_q  <= 1'b0;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_addr_o  = m_addr_q;
    assign bus.m_wdata_o = m_wdata_q;
    assign bus.m_we_o    = m_we_q;
    assign bus.ack0_o    = ack0_q;
    assign bus.ack1_o    = ack1_q;
    assign bus.rdata0_o  = rdata0_q;
    assign bus.rdata1_o  = rdata1_q;
    assign bus.busy_o    = busy_q;

endmodule
